// File: rtl/ram_32to256_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_32to256_wr_ctrl
// Purpose  : Write-side controller for a 32-in / 256-out line buffer RAM.
//            Packs an unstallable 32-bit word stream into a ring of burst
//            slots. Once a slot has been written to the RAM, it is handed to
//            the 256-bit read engine. The slot is freed on burst_done.
// Ports    : wr_clk, wr_rst       clock, synchronous active-high reset
//            frame_start          drops the partial slot, clears overflow
//            din, din_vld         input word stream (cannot be stalled)
//            wr_data/addr/en      RAM write port (registered, latency 1)
//            burst_req            at least one complete slot is pending
//            burst_rd_addr        read start address of the oldest slot
//            burst_done           oldest pending slot has been read
//            pending_cnt          number of complete, unconsumed slots
//            overflow             sticky: a word was dropped while full
// Revision : 1.0 - initial release
// ============================================================================
module ram_32to256_wr_ctrl #(
  parameter int WR_ADDR_WIDTH = 11,
  parameter int WR_DATA_WIDTH = 32,
  parameter int RD_ADDR_WIDTH = 8,
  parameter int BURST_BEATS   = 64
) (
  input  logic                                                   wr_clk,
  input  logic                                                   wr_rst,
  input  logic                                                   frame_start,
  input  logic [WR_DATA_WIDTH-1:0]                               din,
  input  logic                                                   din_vld,
  output logic [WR_DATA_WIDTH-1:0]                               wr_data,
  output logic [WR_ADDR_WIDTH-1:0]                               wr_addr,
  output logic                                                   wr_en,
  output logic                                                   burst_req,
  output logic [RD_ADDR_WIDTH-1:0]                               burst_rd_addr,
  input  logic                                                   burst_done,
  output logic [$clog2((2**RD_ADDR_WIDTH)/BURST_BEATS):0]        pending_cnt,
  output logic                                                   overflow
);

  localparam int c_WORDS_PER_BEAT = 8;
  localparam int c_SLOT_WORDS     = BURST_BEATS * c_WORDS_PER_BEAT;
  localparam int c_NUM_SLOTS      = (2**RD_ADDR_WIDTH) / BURST_BEATS;
  localparam int c_CNT_W          = $clog2(c_NUM_SLOTS) + 1;
  localparam int c_PTR_W          = $clog2(c_SLOT_WORDS);
  localparam int c_SLOT_W         = (c_NUM_SLOTS > 1) ? $clog2(c_NUM_SLOTS) : 1;
  localparam int c_BEAT_SHIFT     = $clog2(BURST_BEATS);

  localparam logic [c_PTR_W-1:0]  c_LAST_PTR  = c_PTR_W'(c_SLOT_WORDS - 1);
  localparam logic [c_SLOT_W-1:0] c_LAST_SLOT = c_SLOT_W'(c_NUM_SLOTS - 1);
  localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(c_NUM_SLOTS);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_drop;

  logic [c_PTR_W-1:0]       r_word_ptr;
  logic [c_SLOT_W-1:0]      r_wr_slot;
  logic [c_SLOT_W-1:0]      r_rd_slot;
  logic                     r_slot_done;
  logic [c_CNT_W-1:0]       r_pending;
  logic                     r_burst_req;
  logic                     r_overflow;
  logic                     r_wr_en;
  logic [WR_ADDR_WIDTH-1:0] r_wr_addr;
  logic [WR_DATA_WIDTH-1:0] r_wr_data;

  logic [c_PTR_W-1:0]       w_eff_ptr;
  logic                     w_last_word;
  logic                     w_done_ok;
  logic [c_CNT_W-1:0]       w_pending_nxt;
  logic [c_SLOT_W-1:0]      w_wr_slot_inc;
  logic [c_SLOT_W-1:0]      w_rd_slot_inc;
  logic [WR_ADDR_WIDTH-1:0] w_addr_nxt;

  // frame_start restarts the slot at offset 0, including for a word
  // arriving in the same cycle.
  assign w_eff_ptr     = frame_start ? '0 : r_word_ptr;
  assign w_last_word   = (w_eff_ptr == c_LAST_PTR);
  assign w_done_ok     = burst_done && (r_pending != '0);
  assign w_wr_slot_inc = (r_wr_slot == c_LAST_SLOT) ? '0 : r_wr_slot + 1'b1;
  assign w_rd_slot_inc = (r_rd_slot == c_LAST_SLOT) ? '0 : r_rd_slot + 1'b1;
  assign w_addr_nxt    = (WR_ADDR_WIDTH'(r_wr_slot) << c_PTR_W) | WR_ADDR_WIDTH'(w_eff_ptr);

  // The completion increment comes from r_slot_done. It lands one cycle after
  // the last RAM write, so the reader never sees a slot before its data.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_slot_done && !w_done_ok) begin
      w_pending_nxt = r_pending + 1'b1;
    end else if (!r_slot_done && w_done_ok) begin
      w_pending_nxt = r_pending - 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = (w_pending_nxt == c_FULL_CNT) ? S_FULL : S_FILL;
    case (r_state)
      S_FILL:  w_accept = din_vld;
      S_FULL:  w_drop   = din_vld;
      default: w_accept = 1'b0;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_word_ptr  <= '0;
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_slot_done <= 1'b0;
      r_pending   <= '0;
      r_burst_req <= 1'b0;
      r_overflow  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en     <= w_accept;
      r_slot_done <= w_accept && w_last_word;
      if (w_accept) begin
        r_wr_addr <= w_addr_nxt;
        r_wr_data <= din;
        if (w_last_word) begin
          r_word_ptr <= '0;
          r_wr_slot  <= w_wr_slot_inc;
        end else begin
          r_word_ptr <= w_eff_ptr + 1'b1;
        end
      end else if (frame_start) begin
        r_word_ptr <= '0;
      end
      if (w_done_ok) begin
        r_rd_slot <= w_rd_slot_inc;
      end
      r_pending   <= w_pending_nxt;
      r_burst_req <= (w_pending_nxt != '0);
      // A drop in the same cycle as frame_start still sets overflow.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (frame_start) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign wr_data       = r_wr_data;
  assign wr_addr       = r_wr_addr;
  assign wr_en         = r_wr_en;
  assign burst_req     = r_burst_req;
  assign burst_rd_addr = RD_ADDR_WIDTH'(r_rd_slot) << c_BEAT_SHIFT;
  assign pending_cnt   = r_pending;
  assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ram_32to256_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_32to256_wr_ctrl
// Purpose  : Self-checking bench for ram_32to256_wr_ctrl. It compares the
//            design every cycle against a slot/queue model of the design.
//            Hand-computed checkpoints pin the model itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_32to256_wr_ctrl;

  localparam int NS = 4;
  localparam int SW = 512;
  localparam int BB = 64;

  logic        wr_clk = 1'b0;
  logic        wr_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [31:0] din = '0;
  logic        din_vld = 1'b0;
  logic        burst_done = 1'b0;
  logic [31:0] wr_data;
  logic [10:0] wr_addr;
  logic        wr_en;
  logic        burst_req;
  logic [7:0]  burst_rd_addr;
  logic [2:0]  pending_cnt;
  logic        overflow;

  ram_32to256_wr_ctrl dut (
    .wr_clk        (wr_clk),
    .wr_rst        (wr_rst),
    .frame_start   (frame_start),
    .din           (din),
    .din_vld       (din_vld),
    .wr_data       (wr_data),
    .wr_addr       (wr_addr),
    .wr_en         (wr_en),
    .burst_req     (burst_req),
    .burst_rd_addr (burst_rd_addr),
    .burst_done    (burst_done),
    .pending_cnt   (pending_cnt),
    .overflow      (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_pend = 0, m_rd = 0, m_wslot = 0, m_off = 0, cyc_t = 0;
  int          due[$];
  bit          m_valid = 0;
  logic        e_wr_en = 0, e_req = 0, e_ovf = 0, e_rst = 1;
  int          e_addr = 0, e_pend = 0, e_rd = 0;
  logic [31:0] e_data = '0;

  initial begin
    forever begin
      @(posedge wr_clk);
      if (wr_rst) begin
        m_pend = 0; m_rd = 0; m_wslot = 0; m_off = 0;
        due.delete();
        e_wr_en = 0; e_req = 0; e_ovf = 0; e_rst = 1;
        e_addr = 0; e_pend = 0; e_rd = 0; e_data = '0;
      end else begin
        bit acc, drop, inc, dec;
        acc  = din_vld && (m_pend != NS);
        drop = din_vld && !acc;
        if (frame_start) m_off = 0;
        e_wr_en = acc;
        e_rst   = 0;
        if (acc) begin
          e_addr = (m_wslot * SW + m_off) % 2048;
          e_data = din;
          m_off++;
          if (m_off == SW) begin
            m_off   = 0;
            m_wslot = (m_wslot + 1) % NS;
            due.push_back(cyc_t + 2);  // visible two cycles after the last word
          end
        end
        if (drop) e_ovf = 1;
        else if (frame_start) e_ovf = 0;
        inc = (due.size() > 0) && (due[0] == cyc_t + 1);
        if (inc) void'(due.pop_front());
        dec = burst_done && (m_pend > 0);
        m_pend = m_pend + int'(inc) - int'(dec);
        if (dec) m_rd = (m_rd + 1) % NS;
        e_pend = m_pend;
        e_req  = (m_pend != 0);
        e_rd   = m_rd * BB;
      end
      cyc_t++;
      m_valid = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge wr_clk);
      if (m_valid) begin
        chk("wr_en", wr_en, e_wr_en);
        chk("pending_cnt", pending_cnt, e_pend);
        chk("burst_req", burst_req, e_req);
        chk("burst_rd_addr", burst_rd_addr, e_rd);
        chk("overflow", overflow, e_ovf);
        if (e_wr_en || e_rst) begin
          chk("wr_addr", wr_addr, e_addr);
          chk("wr_data", wr_data, e_data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic word(input logic [31:0] d);
    din     = d;
    din_vld = 1'b1;
    cyc();
    din_vld = 1'b0;
  endtask

  task automatic pulse_done();
    burst_done = 1'b1;
    cyc();
    burst_done = 1'b0;
  endtask

  task automatic reset_dut();
    wr_rst = 1'b1; din_vld = 1'b0; burst_done = 1'b0; frame_start = 1'b0;
    idle(3);
    wr_rst = 1'b0;
  endtask

  initial begin
    int seq[6] = '{0, 64, 128, 192, 0, 64};
    int rate[4] = '{0, 1, 3, 50};

    // 1: reset held with din_vld toggling
    wr_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_vld = i[0];
      din     = $urandom;
      cyc();
    end
    chk("rst_wr_en", wr_en, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_req", burst_req, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_addr", wr_addr, 0);
    din_vld = 1'b0;
    wr_rst  = 1'b0;

    // 2: one full slot, data = index
    for (int i = 0; i < SW; i++) begin
      word(i);
      if (i == 0) begin
        chk("t2_first_addr", wr_addr, 0);
        chk("t2_first_data", wr_data, 0);
      end
    end
    chk("t2_last_addr", wr_addr, 511);
    chk("t2_last_data", wr_data, 511);
    chk("t2_pend_early", pending_cnt, 0);
    idle(1);
    chk("t2_pend", pending_cnt, 1);
    chk("t2_req", burst_req, 1);
    chk("t2_rdaddr", burst_rd_addr, 0);

    // 3: fill all slots, then overflow
    reset_dut();
    for (int i = 0; i < 4 * SW; i++) word(1000 + i);
    chk("t3_last_addr", wr_addr, 2047);
    idle(2);
    chk("t3_pend_full", pending_cnt, 4);
    word(32'hDEAD_BEEF);
    chk("t3_drop_wr_en", wr_en, 0);
    chk("t3_ovf", overflow, 1);
    pulse_done();
    chk("t3_pend_after_done", pending_cnt, 3);
    chk("t3_rdaddr", burst_rd_addr, 64);
    word(7);
    chk("t3_wrap_addr", wr_addr, 0);
    chk("t3_wrap_data", wr_data, 7);

    // 5: frame_start mid-slot clears overflow and restarts at offset 0
    repeat (3) pulse_done();
    chk("t5_pend_drained", pending_cnt, 0);
    chk("t5_ovf_sticky", overflow, 1);
    for (int i = 0; i < 99; i++) word(i);
    frame_start = 1'b1;
    word(32'hA5A5_A5A5);
    frame_start = 1'b0;
    chk("t5_fs_addr", wr_addr, 0);
    chk("t5_fs_data", wr_data, 32'hA5A5_A5A5);
    chk("t5_fs_ovf", overflow, 0);
    for (int i = 0; i < 510; i++) word(i);
    idle(2);
    chk("t5_no_req", burst_req, 0);
    word(32'h1234);
    idle(1);
    chk("t5_req", burst_req, 1);
    chk("t5_rdaddr", burst_rd_addr, 0);

    // 4: burst_done coincides with slot-1 completion increment
    reset_dut();
    for (int i = 0; i < SW; i++) word(i);
    idle(2);
    chk("t4_pend1", pending_cnt, 1);
    for (int i = 0; i < SW; i++) word(i);
    chk("t4_pend_pre", pending_cnt, 1);
    chk("t4_rd_pre", burst_rd_addr, 0);
    pulse_done();
    chk("t4_pend_post", pending_cnt, 1);
    chk("t4_rd_post", burst_rd_addr, 64);

    // 6: six slots, each consumed after completion
    reset_dut();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < SW; i++) word(s * SW + i);
      idle(1);
      chk("t6_rdaddr", burst_rd_addr, seq[s]);
      chk("t6_pend", pending_cnt, 1);
      pulse_done();
    end
    chk("t6_pend_empty", pending_cnt, 0);
    pulse_done();
    chk("t6_ign_pend", pending_cnt, 0);
    chk("t6_ign_rdaddr", burst_rd_addr, 128);

    // random traffic, with burst_done rate varying per epoch
    reset_dut();
    for (int e = 0; e < 4; e++) begin
      for (int c = 0; c < 2000; c++) begin
        din_vld     = ($urandom_range(0, 99) < 85);
        din         = $urandom;
        burst_done  = ($urandom_range(0, 999) < rate[e] * 2);
        frame_start = ($urandom_range(0, 999) < 2);
        cyc();
      end
    end
    din_vld = 1'b0; burst_done = 1'b0; frame_start = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
